pc_sp_unit: RTL and testbench

- Parametrised next-generation program-counter / stack-pointer unit for the multi-cycle core; replaces the fixed 16-bit PC/SP logic.
- Adds a hardware return-address stack (RAS), banked user/kernel stack pointers, and trap entry/return with an exception PC (EPC).
- Driven by the control unit each cycle. Feeds the PC to instruction memory and the active SP to data-memory addressing.

---
 rtl/pc_sp_unit.sv | 203 ++++++++++++++++++++
 tb/tb_pc_sp_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sp_unit.sv
// Program-counter / stack-pointer unit: PC sequencing, hardware return-address
// stack, banked user/kernel stack pointers, and trap entry/return via EPC.
module pc_sp_unit #(
    parameter int unsigned      WIDTH          = 16,
    parameter int unsigned      RAS_DEPTH      = 8,
    parameter int unsigned      STEP           = 2,
    parameter logic [WIDTH-1:0] RESET_PC       = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR    = 16'h0010,
    parameter logic [WIDTH-1:0] USER_SP_INIT   = 16'hEFFE,
    parameter logic [WIDTH-1:0] KERNEL_SP_INIT = 16'hFFFE
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [2:0]                     pc_cmd,
    input  logic [1:0]                     sp_cmd,
    input  logic [WIDTH-1:0]               target,
    input  logic [WIDTH-1:0]               se_imm,
    input  logic [WIDTH-1:0]               sp_wdata,
    input  logic [WIDTH-1:0]               ra_fallback,
    input  logic                           clear_flags,
    output logic [WIDTH-1:0]               pc_out,
    output logic [WIDTH-1:0]               sp_out,
    output logic [WIDTH-1:0]               epc_out,
    output logic                           in_kernel,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic [WIDTH-1:0]               ras_top,
    output logic                           ras_overflow,
    output logic                           ras_underflow,
    output logic                           priv_fault,
    output logic                           double_fault
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

    typedef enum logic [2:0] {
        PC_HOLD, PC_INC, PC_BRANCH, PC_JUMP, PC_CALL, PC_RET, PC_TRAP, PC_ERET
    } pc_cmd_e;

    typedef enum logic [1:0] {
        SP_HOLD, SP_PUSH, SP_POP, SP_LOAD
    } sp_cmd_e;

    typedef enum logic {
        MODE_USER   = 1'b0,
        MODE_KERNEL = 1'b1
    } mode_e;

    pc_cmd_e pc_op;
    sp_cmd_e sp_op;

    logic [WIDTH-1:0] pc_q,  pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] usp_q, usp_d;
    logic [WIDTH-1:0] ksp_q, ksp_d;
    mode_e            mode_q, mode_d;

    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr_q, ras_ptr_d;
    logic [CW-1:0]    ras_cnt_q, ras_cnt_d;

    logic ovf_q,  ovf_d;
    logic unf_q,  unf_d;
    logic priv_q, priv_d;
    logic dbl_q,  dbl_d;

    logic [WIDTH-1:0] pc_seq;
    logic [PW-1:0]    ras_top_idx;
    logic             ras_full;
    logic             ras_empty;
    logic             kernel_now;
    logic [WIDTH-1:0] sp_active;
    logic [WIDTH-1:0] sp_next;

    assign pc_op       = pc_cmd_e'(pc_cmd);
    assign sp_op       = sp_cmd_e'(sp_cmd);
    assign pc_seq      = pc_q + STEP_W;
    assign ras_top_idx = ras_ptr_q - PW'(1);
    assign ras_full    = (ras_cnt_q == DEPTH_C);
    assign ras_empty   = (ras_cnt_q == '0);
    assign kernel_now  = (mode_q == MODE_KERNEL);
    assign sp_active   = kernel_now ? ksp_q : usp_q;

    always_comb begin
        sp_next = sp_active;
        case (sp_op)
            SP_PUSH: sp_next = sp_active - STEP_W;
            SP_POP:  sp_next = sp_active + STEP_W;
            SP_LOAD: sp_next = sp_wdata;
            default: sp_next = sp_active;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        epc_d     = epc_q;
        mode_d    = mode_q;
        ras_mem_d = ras_mem_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        // Clear first so a fault raised in the same cycle still lands set.
        ovf_d     = ovf_q  & ~clear_flags;
        unf_d     = unf_q  & ~clear_flags;
        priv_d    = priv_q & ~clear_flags;
        dbl_d     = dbl_q  & ~clear_flags;

        // Bank is chosen from the pre-transition mode.
        usp_d = kernel_now ? usp_q   : sp_next;
        ksp_d = kernel_now ? sp_next : ksp_q;

        case (pc_op)
            PC_HOLD:   pc_d = pc_q;
            PC_INC:    pc_d = pc_seq;
            PC_BRANCH: pc_d = pc_q + se_imm;
            PC_JUMP:   pc_d = target;
            PC_CALL: begin
                // Write pointer wraps onto the oldest entry once full.
                ras_mem_d[ras_ptr_q] = pc_seq;
                ras_ptr_d            = ras_ptr_q + PW'(1);
                if (ras_full) begin
                    ovf_d = 1'b1;
                end else begin
                    ras_cnt_d = ras_cnt_q + CW'(1);
                end
                pc_d = target;
            end
            PC_RET: begin
                if (!ras_empty) begin
                    pc_d      = ras_mem_q[ras_top_idx];
                    ras_ptr_d = ras_top_idx;
                    ras_cnt_d = ras_cnt_q - CW'(1);
                end else begin
                    pc_d  = ra_fallback;
                    unf_d = 1'b1;
                end
            end
            PC_TRAP: begin
                if (kernel_now) begin
                    dbl_d = 1'b1;
                end else begin
                    epc_d  = pc_seq;
                    mode_d = MODE_KERNEL;
                end
                pc_d = TRAP_VECTOR;
            end
            PC_ERET: begin
                if (kernel_now) begin
                    pc_d   = epc_q;
                    mode_d = MODE_USER;
                end else begin
                    pc_d   = pc_seq;
                    priv_d = 1'b1;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            epc_q     <= '0;
            usp_q     <= USER_SP_INIT;
            ksp_q     <= KERNEL_SP_INIT;
            mode_q    <= MODE_KERNEL;
            ras_mem_q <= '{default: '0};
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            priv_q    <= 1'b0;
            dbl_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            usp_q     <= usp_d;
            ksp_q     <= ksp_d;
            mode_q    <= mode_d;
            ras_mem_q <= ras_mem_d;
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            priv_q    <= priv_d;
            dbl_q     <= dbl_d;
        end
    end

    assign pc_out        = pc_q;
    assign sp_out        = sp_active;
    assign epc_out       = epc_q;
    assign in_kernel     = kernel_now;
    assign ras_count     = ras_cnt_q;
    assign ras_top       = ras_empty ? '0 : ras_mem_q[ras_top_idx];
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign priv_fault    = priv_q;
    assign double_fault  = dbl_q;

endmodule

// File: tb/tb_pc_sp_unit.sv
// Bench for pc_sp_unit: a queue-based reference model checked every cycle,
// plus directed literal expectations from hand-worked scenarios.
module tb_pc_sp_unit;

    localparam int unsigned W = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [2:0]    pc_cmd;
    logic [1:0]    sp_cmd;
    logic [W-1:0]  target, se_imm, sp_wdata, ra_fallback;
    logic          clear_flags;
    logic [W-1:0]  pc_out, sp_out, epc_out, ras_top;
    logic          in_kernel, ras_overflow, ras_underflow, priv_fault, double_fault;
    logic [3:0]    ras_count;

    pc_sp_unit #(
        .WIDTH(16), .RAS_DEPTH(8), .STEP(2), .RESET_PC(16'h0000),
        .TRAP_VECTOR(16'h0010), .USER_SP_INIT(16'hEFFE), .KERNEL_SP_INIT(16'hFFFE)
    ) dut (
        .clock(clock), .reset(reset), .pc_cmd(pc_cmd), .sp_cmd(sp_cmd),
        .target(target), .se_imm(se_imm), .sp_wdata(sp_wdata),
        .ra_fallback(ra_fallback), .clear_flags(clear_flags),
        .pc_out(pc_out), .sp_out(sp_out), .epc_out(epc_out), .in_kernel(in_kernel),
        .ras_count(ras_count), .ras_top(ras_top), .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow), .priv_fault(priv_fault), .double_fault(double_fault)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    logic [W-1:0] m_pc, m_epc, m_usp, m_ksp;
    bit           m_k, m_ovf, m_unf, m_priv, m_dbl;
    logic [W-1:0] m_ras[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_epc = '0; m_usp = 16'hEFFE; m_ksp = 16'hFFFE;
        m_k = 1'b1; m_ovf = 0; m_unf = 0; m_priv = 0; m_dbl = 0;
        m_ras.delete();
    endtask

    task automatic model_step();
        logic [W-1:0] sp;
        bit           k_old;
        k_old = m_k;
        if (clear_flags) begin
            m_ovf = 0; m_unf = 0; m_priv = 0; m_dbl = 0;
        end
        sp = k_old ? m_ksp : m_usp;
        case (sp_cmd)
            2'd1: sp = sp - 16'd2;
            2'd2: sp = sp + 16'd2;
            2'd3: sp = sp_wdata;
            default: ;
        endcase
        if (k_old) m_ksp = sp; else m_usp = sp;
        case (pc_cmd)
            3'd1: m_pc = m_pc + 16'd2;
            3'd2: m_pc = m_pc + se_imm;
            3'd3: m_pc = target;
            3'd4: begin
                if (m_ras.size() == 8) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1;
                end
                m_ras.push_back(m_pc + 16'd2);
                m_pc = target;
            end
            3'd5: begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin m_pc = ra_fallback; m_unf = 1; end
            end
            3'd6: begin
                if (k_old) m_dbl = 1;
                else begin m_epc = m_pc + 16'd2; m_k = 1; end
                m_pc = 16'h0010;
            end
            3'd7: begin
                if (k_old) begin m_pc = m_epc; m_k = 0; end
                else begin m_pc = m_pc + 16'd2; m_priv = 1; end
            end
            default: ;
        endcase
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("pc_out",        32'(pc_out),        32'(m_pc));
            chk("sp_out",        32'(sp_out),        32'(m_k ? m_ksp : m_usp));
            chk("epc_out",       32'(epc_out),       32'(m_epc));
            chk("in_kernel",     32'(in_kernel),     32'(m_k));
            chk("ras_count",     32'(ras_count),     32'(m_ras.size()));
            chk("ras_top",       32'(ras_top),       (m_ras.size() == 0) ? 32'h0 : 32'(m_ras[$]));
            chk("ras_overflow",  32'(ras_overflow),  32'(m_ovf));
            chk("ras_underflow", 32'(ras_underflow), 32'(m_unf));
            chk("priv_fault",    32'(priv_fault),    32'(m_priv));
            chk("double_fault",  32'(double_fault),  32'(m_dbl));
        end
    end

    task automatic cyc(input logic [2:0] pc, input logic [1:0] sp,
                       input logic [W-1:0] tgt = '0, input logic [W-1:0] imm = '0,
                       input logic [W-1:0] wd = '0, input logic [W-1:0] fb = '0,
                       input logic clr = 1'b0, input logic rst = 1'b0);
        pc_cmd = pc; sp_cmd = sp; target = tgt; se_imm = imm;
        sp_wdata = wd; ra_fallback = fb; clear_flags = clr; reset = rst;
        @(posedge clock);
        if (rst) model_reset(); else model_step();
        #1;
        reset = 1'b0; clear_flags = 1'b0;
    endtask

    initial begin
        model_reset();
        pc_cmd = '0; sp_cmd = '0; target = '0; se_imm = '0;
        sp_wdata = '0; ra_fallback = '0; clear_flags = 0; reset = 1;
        cyc(3'd0, 2'd0, .rst(1'b1));
        chk_en = 1'b1;
        cyc(3'd1, 2'd0, .rst(1'b1));
        chk("rst_pc", 32'(pc_out), 32'h0000);
        chk("rst_sp", 32'(sp_out), 32'hFFFE);
        chk("rst_kernel", 32'(in_kernel), 32'h1);

        repeat (3) cyc(3'd1, 2'd0);
        chk("inc3_pc", 32'(pc_out), 32'h0006);
        cyc(3'd7, 2'd0);
        chk("eret_pc", 32'(pc_out), 32'h0000);
        chk("eret_mode", 32'(in_kernel), 32'h0);
        chk("eret_sp", 32'(sp_out), 32'hEFFE);

        cyc(3'd3, 2'd0, .tgt(16'h0100));
        cyc(3'd4, 2'd0, .tgt(16'h0200));
        chk("call_pc", 32'(pc_out), 32'h0200);
        chk("call_top", 32'(ras_top), 32'h0102);
        chk("call_cnt", 32'(ras_count), 32'h1);
        cyc(3'd5, 2'd0);
        chk("ret_pc", 32'(pc_out), 32'h0102);
        chk("ret_cnt", 32'(ras_count), 32'h0);
        chk("ret_top", 32'(ras_top), 32'h0000);

        cyc(3'd3, 2'd0, .tgt(16'h0000));
        for (int i = 1; i <= 9; i++) cyc(3'd4, 2'd0, .tgt(16'(i * 16'h1000)));
        chk("ovf_cnt", 32'(ras_count), 32'h8);
        chk("ovf_flag", 32'(ras_overflow), 32'h1);
        for (int i = 8; i >= 1; i--) begin
            cyc(3'd5, 2'd0);
            chk("ret_chain_pc", 32'(pc_out), 32'(16'((i * 16'h1000) + 16'h0002)));
        end
        cyc(3'd5, 2'd0, .fb(16'h0ABC));
        chk("unf_pc", 32'(pc_out), 32'h0ABC);
        chk("unf_flag", 32'(ras_underflow), 32'h1);

        cyc(3'd3, 2'd0, .tgt(16'h0040));
        cyc(3'd6, 2'd1);
        chk("trap_pc", 32'(pc_out), 32'h0010);
        chk("trap_epc", 32'(epc_out), 32'h0042);
        chk("trap_sp", 32'(sp_out), 32'hFFFE);
        cyc(3'd6, 2'd0);
        chk("dbl_flag", 32'(double_fault), 32'h1);
        chk("dbl_epc", 32'(epc_out), 32'h0042);
        cyc(3'd7, 2'd0);
        chk("ret_user_sp", 32'(sp_out), 32'hEFFC);

        cyc(3'd3, 2'd0, .tgt(16'h0002));
        cyc(3'd2, 2'd0, .imm(16'hFFFC));
        chk("branch_wrap", 32'(pc_out), 32'hFFFE);
        cyc(3'd0, 2'd3, .wd(16'h0000));
        cyc(3'd0, 2'd2);
        chk("load_pop_sp", 32'(sp_out), 32'h0002);
        cyc(3'd6, 2'd0);
        chk("ksp_kept", 32'(sp_out), 32'hFFFE);
        cyc(3'd0, 2'd1);
        chk("kpush", 32'(sp_out), 32'hFFFC);
        cyc(3'd7, 2'd2);
        chk("eret_pop_usp", 32'(sp_out), 32'h0002);
        cyc(3'd6, 2'd0);
        chk("kpop_applied", 32'(sp_out), 32'hFFFE);
        cyc(3'd0, 2'd1, .clr(1'b1));
        chk("clr_dbl", 32'(double_fault), 32'h0);
        cyc(3'd7, 2'd0);

        repeat (3) cyc(3'd4, 2'd0, .tgt(16'h0300));
        chk("pre_rst_cnt", 32'(ras_count), 32'h3);
        cyc(3'd7, 2'd0);
        chk("pre_rst_priv", 32'(priv_fault), 32'h1);
        cyc(3'd4, 2'd1, .tgt(16'h0500), .rst(1'b1));
        chk("mid_rst_pc", 32'(pc_out), 32'h0000);
        chk("mid_rst_cnt", 32'(ras_count), 32'h0);
        chk("mid_rst_priv", 32'(priv_fault), 32'h0);
        chk("mid_rst_sp", 32'(sp_out), 32'hFFFE);
        cyc(3'd7, 2'd0);
        cyc(3'd7, 2'd0, .clr(1'b1));
        chk("clr_vs_priv", 32'(priv_fault), 32'h1);
        cyc(3'd0, 2'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
